// File: rtl/reg_file_mp.sv
// Multi-port register file: three combinational reads, two write ports (port 0 wins on collision),
// plus a ready/valid register-dump streamer. Define REGF_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_stream;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (in_range(a)) begin
      v = r_regs[a];
`ifdef REGF_BYPASS_EN
      if (!rst && we0 && waddr0 == a)
        v = wdata0;
      else if (!rst && we1 && waddr1 == a)
        v = wdata1;
`endif
    end
    return v;
  endfunction

  // Port 1 is applied first so a colliding port 0 write overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        r_regs[i] <= DATA_W'(i);
    end else begin
      if (we1 && in_range(waddr1))
        r_regs[waddr1] <= wdata1;
      if (we0 && in_range(waddr0))
        r_regs[waddr0] <= wdata0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_state <= S_STREAM;
            r_cnt   <= '0;
          end
        end
        S_STREAM: begin
          if (dump_ready) begin
            if (r_cnt == LAST_IDX) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + ADDR_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Dump data reads the stored array directly, so a write to the held index shows up one cycle later.
  always_comb begin
    w_stream   = (r_state == S_STREAM);
    dump_valid = w_stream;
    dump_busy  = w_stream;
    dump_idx   = w_stream ? r_cnt : '0;
    dump_data  = w_stream ? r_regs[r_cnt] : '0;
  end

  always_comb begin
    rd_data0 = read_port(rd_addr0);
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic against an array/flag reference model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int NR = 15;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data0, rd_data1, rd_data2;
  logic          we0, we1;
  logic [AW-1:0] waddr0, waddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          dump_req, dump_ready;
  logic          dump_valid, dump_busy;
  logic [AW-1:0] dump_idx;
  logic [DW-1:0] dump_data;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_stream;
  int            m_idx;

  reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .dump_req(dump_req), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_busy(dump_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = DW'(i);
    m_stream = 1'b0;
    m_idx    = 0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (int'(a) >= NR) return '0;
`ifdef REGF_BYPASS_EN
    if (!rst && we0 && waddr0 == a) return wdata0;
    if (!rst && we1 && waddr1 == a) return wdata1;
`endif
    return m_regs[a];
  endfunction

  task automatic idle_inputs();
    we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    dump_req = 0; dump_ready = 0;
    rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_stream) begin
        if (dump_ready) begin
          if (m_idx == NR - 1) begin
            m_stream = 1'b0;
            m_idx    = 0;
          end else begin
            m_idx++;
          end
        end
      end else if (dump_req) begin
        m_stream = 1'b1;
        m_idx    = 0;
      end
      if (we1 && int'(waddr1) < NR) m_regs[waddr1] = wdata1;
      if (we0 && int'(waddr0) < NR) m_regs[waddr0] = wdata0;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, "_rd0"}, rd_data0, exp_rd(rd_addr0));
    chk({tag, "_rd1"}, rd_data1, exp_rd(rd_addr1));
    chk({tag, "_rd2"}, rd_data2, exp_rd(rd_addr2));
    chk({tag, "_dvalid"}, DW'(dump_valid), DW'(m_stream));
    chk({tag, "_dbusy"}, DW'(dump_busy), DW'(m_stream));
    chk({tag, "_didx"}, DW'(dump_idx), m_stream ? DW'(m_idx) : '0);
    chk({tag, "_ddata"}, dump_data, m_stream ? m_regs[m_idx] : '0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_dvalid", DW'(dump_valid), '0);
    chk("rst_dbusy", DW'(dump_busy), '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();

    // Reset release read-back with an out-of-range address.
    do_reset();
    rd_addr0 = 4'd7; rd_addr1 = 4'd14; rd_addr2 = 4'd15;
    #1;
    chk("r021_rd0", rd_data0, 32'd7);
    chk("r021_rd1", rd_data1, 32'd14);
    chk("r021_rd2", rd_data2, 32'd0);
    check_all("r021");
    tick();

    // Write collision on reg 3: port 0 wins.
    we0 = 1; waddr0 = 4'd3; wdata0 = 32'hDEAD;
    we1 = 1; waddr1 = 4'd3; wdata1 = 32'hBEEF;
    rd_addr0 = 4'd3;
    #1;
`ifdef REGF_BYPASS_EN
    chk("r022_same", rd_data0, 32'hDEAD);
`else
    chk("r022_same", rd_data0, 32'd3);
`endif
    check_all("r022a");
    tick();
    idle_inputs();
    rd_addr0 = 4'd3;
    #1;
    chk("r022_after", rd_data0, 32'hDEAD);
    check_all("r022b");

    // Out-of-range write is dropped.
    we1 = 1; waddr1 = 4'd15; wdata1 = 32'h55;
    tick();
    idle_inputs();
    for (int k = 0; k < NR; k++) begin
      rd_addr0 = AW'(k);
      #1;
      chk("r023_reg", rd_data0, (k == 3) ? 32'hDEAD : DW'(k));
    end
    check_all("r023");

    // Full dump with constant ready.
    do_reset();
    dump_req = 1;
    check_all("r024_req");
    tick();
    dump_req = 0; dump_ready = 1;
    for (int k = 0; k < NR; k++) begin
      #1;
      chk("r024_valid", DW'(dump_valid), 32'd1);
      chk("r024_idx", DW'(dump_idx), DW'(k));
      chk("r024_data", dump_data, DW'(k));
      check_all("r024");
      tick();
    end
    #1;
    chk("r024_done_busy", DW'(dump_busy), 32'd0);
    chk("r024_done_valid", DW'(dump_valid), 32'd0);

    // Back-pressure at index 5 while reg 5 is rewritten.
    do_reset();
    dump_req = 1;
    tick();
    dump_req = 0; dump_ready = 1;
    for (int g = 0; g < 20 && m_idx != 5; g++) begin
      check_all("r025_run");
      tick();
    end
    chk("r025_reach5", DW'(dump_idx), 32'd5);
    dump_ready = 0;
    we0 = 1; waddr0 = 4'd5; wdata0 = 32'h99;
    check_all("r025_w");
    tick();
    we0 = 0;
    for (int s = 0; s < 2; s++) begin
      #1;
      chk("r025_hold_idx", DW'(dump_idx), 32'd5);
      chk("r025_hold_data", dump_data, 32'h99);
      check_all("r025_hold");
      tick();
    end
    dump_ready = 1;
    #1;
    chk("r025_acc_idx", DW'(dump_idx), 32'd5);
    chk("r025_acc_data", dump_data, 32'h99);
    check_all("r025_acc");
    tick();
    #1;
    chk("r025_next_idx", DW'(dump_idx), 32'd6);

    // Reset mid-dump at index 8.
    for (int g = 0; g < 20 && m_idx != 8; g++) begin
      check_all("r026_run");
      tick();
    end
    chk("r026_reach8", DW'(dump_idx), 32'd8);
    rst = 1'b1;
    #1;
    chk("r026_valid", DW'(dump_valid), 32'd0);
    chk("r026_busy", DW'(dump_busy), 32'd0);
    chk("r026_idx", DW'(dump_idx), 32'd0);
    chk("r026_data", dump_data, 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    idle_inputs();
    dump_ready = 1;
    tick();
    #1;
    chk("r026_idle_busy", DW'(dump_busy), 32'd0);
    for (int k = 0; k < NR; k++) begin
      rd_addr1 = AW'(k);
      #1;
      chk("r026_reg", rd_data1, DW'(k));
    end
    check_all("r026");

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      we0        = ($urandom_range(0, 1) == 1);
      we1        = ($urandom_range(0, 1) == 1);
      waddr0     = AW'($urandom_range(0, 15));
      waddr1     = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, 15));
      wdata0     = $urandom;
      wdata1     = $urandom;
      rd_addr0   = AW'($urandom_range(0, 15));
      rd_addr1   = ($urandom_range(0, 2) == 0) ? waddr0 : AW'($urandom_range(0, 15));
      rd_addr2   = ($urandom_range(0, 2) == 0) ? waddr1 : AW'($urandom_range(0, 15));
      dump_req   = ($urandom_range(0, 7) == 0);
      dump_ready = ($urandom_range(0, 9) < 7);
      check_all("rand");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
